prefetch_queue: RTL

Instruction prefetch buffer between instruction memory and the `fetch` stage of `fewcore`. It issues sequential word fetches and holds up to DEPTH returned instructions, each tagged with its PC, in a FIFO. `fetch` pops them as it consumes them. A branch redirect from `execute` (`originPc`/`pcBranch`) flushes the buffer and restarts fetching at the target.

---
 rtl/prefetch_queue.sv | 63 ++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: sequential instruction prefetch FIFO with redirect flush
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_ack,
  input  logic [31:0]                  mem_rdata,
  output logic                         out_valid,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [31:0]    inst_q [DEPTH];
  logic [31:0]    pc_q   [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [31:0]    fetch_pc, fetch_pc_next;
  logic [CW-1:0]  count_next;
  logic           push, pop;
  logic           unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign push      = mem_req & mem_ack;
  assign pop       = out_valid & out_ready;
  assign out_valid = count != '0;
  assign out_inst  = inst_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  always_comb begin
    fetch_pc_next = redirect ? {redirect_pc[31:2], 2'b00} : push ? fetch_pc + 32'd4 : fetch_pc;
    count_next    = redirect ? '0 : count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      rd_ptr   <= redirect ? '0 : pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr   <= redirect ? '0 : push ? wr_ptr + AW'(1) : wr_ptr;
      count    <= count_next;
      fetch_pc <= fetch_pc_next;
      mem_req  <= count_next < CW'(DEPTH);
      mem_addr <= fetch_pc_next;
    end
  end
  // storage needs no reset; a redirect or reset discards the incoming word
  always_ff @(posedge clk) begin
    if (push && !redirect && !reset) begin
      inst_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]   <= mem_addr;
    end
  end
endmodule
